// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares the data-side port of the CPU memory (combinational read path
// fetch_addr/fetched_data plus the write path write_addr/write_data/
// bytes_to_write) between NUM_REQ requesters. Requesters are granted
// round-robin, and only one transaction is in flight at a time. Each
// transaction takes three cycles: IDLE (accept), ACCESS (memory access) and
// RESP (response held until it is consumed).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  per-requester request handshake (ready is one-hot or 0)
//   req_write            1 = write, 0 = read
//   req_size             3 bits per requester, byte count 1, 2 or 4
//   req_addr, req_wdata  packed per-requester byte address and write data
//   resp_valid/ready     per-requester response handshake
//   resp_rdata, resp_err shared response bus, qualified by resp_valid
//   mem_*                memory data port (bytes_to_write = 0 means no write)
//
// Optional build macro MEM_ARB_ALIGN_CHECK_EN: when defined, misaligned
// 2-byte and 4-byte requests are rejected like invalid sizes (no write,
// rdata = 0, resp_err = 1). When undefined, addresses pass through unaligned.

module mem_port_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [3*NUM_REQ-1:0]      req_size,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        resp_valid,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic                      resp_err,
    output logic [ADDR_W-1:0]         mem_fetch_addr,
    input  logic [DATA_W-1:0]         mem_fetched_data,
    output logic [ADDR_W-1:0]         mem_write_addr,
    output logic [DATA_W-1:0]         mem_write_data,
    output logic [2:0]                mem_bytes_to_write
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       rr_q, rr_d;
    logic [GW-1:0]       gnt_q, gnt_d;
    logic                write_q, write_d;
    logic [2:0]          size_q, size_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                resp_err_q, resp_err_d;

    // Unpacked per-requester views of the packed request buses.
    logic [2:0]        size_arr  [NUM_REQ];
    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign size_arr[gi]  = req_size[3*gi +: 3];
            assign addr_arr[gi]  = req_addr[ADDR_W*gi +: ADDR_W];
            assign wdata_arr[gi] = req_wdata[DATA_W*gi +: DATA_W];
        end
    endgenerate

    // (base + off) mod NUM_REQ, for off < NUM_REQ.
    function automatic logic [GW-1:0] rr_index(input logic [GW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return GW'(sum);
    endfunction

    // Round-robin search: first valid requester at or after the pointer.
    logic          gnt_found;
    logic [GW-1:0] gnt_idx;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!gnt_found && req_valid[rr_index(rr_q, off)]) begin
                gnt_found = 1'b1;
                gnt_idx   = rr_index(rr_q, off);
            end
        end
    end

    // Classify the candidate request; a bad request still gets a response
    // but never touches memory.
    logic [2:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic              req_bad;

    always_comb begin
        sel_size = size_arr[gnt_idx];
        sel_addr = addr_arr[gnt_idx];
        req_bad  = !(sel_size == 3'd1 || sel_size == 3'd2 || sel_size == 3'd4);
`ifdef MEM_ARB_ALIGN_CHECK_EN
        if (sel_size == 3'd2 && sel_addr[0]) begin
            req_bad = 1'b1;
        end
        if (sel_size == 3'd4 && sel_addr[1:0] != 2'b00) begin
            req_bad = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        gnt_d        = gnt_q;
        write_d      = write_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        resp_err_d   = resp_err_q;

        unique case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    gnt_d   = gnt_idx;
                    write_d = req_write[gnt_idx];
                    size_d  = sel_size;
                    addr_d  = sel_addr;
                    wdata_d = wdata_arr[gnt_idx];
                    err_d   = req_bad;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Writes and rejected requests answer with zero data.
                rdata_d      = (!write_q && !err_q) ? mem_fetched_data : '0;
                resp_err_d   = err_q;
                resp_valid_d = NUM_REQ'(1) << gnt_q;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready[gnt_q]) begin
                    resp_valid_d = '0;
                    rr_d         = rr_index(gnt_q, 1);
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            gnt_q        <= '0;
            write_q      <= 1'b0;
            size_q       <= 3'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= '0;
            rdata_q      <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            gnt_q        <= gnt_d;
            write_q      <= write_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // The accept strobe is combinational; gating with rst_n keeps it low
    // while reset is held even if requesters are already asserting valid.
    assign req_ready = (rst_n && state_q == IDLE && gnt_found)
                     ? (NUM_REQ'(1) << gnt_idx) : '0;

    // Decoded from state so an asynchronous reset removes it at once.
    assign mem_bytes_to_write = (state_q == ACCESS && write_q && !err_q) ? size_q : 3'd0;

    assign mem_fetch_addr = addr_q;
    assign mem_write_addr = addr_q;
    assign mem_write_data = wdata_q;

    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// -------------------
// Self-checking bench for mem_port_arbiter (NUM_REQ = 2, 32-bit address and
// data). A byte-addressed memory behind the DUT and a reference byte array
// in the bench track the expected contents; responses are predicted from
// the request rules (legal sizes, optional alignment, little-endian bytes)
// and the round-robin order from a simple pointer. Build macro
// MEM_ARB_ALIGN_CHECK_EN selects the expected values for the alignment check.

module tb_mem_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_write = '0;
    logic [3*N-1:0]  req_size = '0;
    logic [AW*N-1:0] req_addr = '0;
    logic [DW*N-1:0] req_wdata = '0;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready = '0;
    logic [DW-1:0]   resp_rdata;
    logic            resp_err;
    logic [AW-1:0]   mem_fetch_addr;
    logic [DW-1:0]   mem_fetched_data;
    logic [AW-1:0]   mem_write_addr;
    logic [DW-1:0]   mem_write_data;
    logic [2:0]      mem_bytes_to_write;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_write          (req_write),
        .req_size           (req_size),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .resp_valid         (resp_valid),
        .resp_ready         (resp_ready),
        .resp_rdata         (resp_rdata),
        .resp_err           (resp_err),
        .mem_fetch_addr     (mem_fetch_addr),
        .mem_fetched_data   (mem_fetched_data),
        .mem_write_addr     (mem_write_addr),
        .mem_write_data     (mem_write_data),
        .mem_bytes_to_write (mem_bytes_to_write)
    );

    // Memory behind the DUT: combinational word read, byte writes on posedge.
    logic [7:0]  tb_mem  [0:4095] = '{default: 8'h00};
    logic [7:0]  ref_mem [0:4095] = '{default: 8'h00};
    logic [11:0] fa, wa;
    int          wr_pulses = 0;

    assign fa = mem_fetch_addr[11:0];
    assign wa = mem_write_addr[11:0];
    assign mem_fetched_data = {tb_mem[fa + 12'd3], tb_mem[fa + 12'd2],
                               tb_mem[fa + 12'd1], tb_mem[fa]};

    always @(posedge clk) begin
        if (mem_bytes_to_write != 3'd0) begin
            wr_pulses <= wr_pulses + 1;
            for (int i = 0; i < 4; i++) begin
                if (i < int'(mem_bytes_to_write)) begin
                    tb_mem[wa + 12'(i)] <= mem_write_data[8*i +: 8];
                end
            end
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Pending request per requester, and the reference round-robin pointer.
    logic        p_valid [N];
    logic        p_wr    [N];
    logic [2:0]  p_size  [N];
    logic [31:0] p_addr  [N];
    logic [31:0] p_wdata [N];
    int          rr_m = 0;

    task automatic drive_ports();
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = p_valid[i];
            req_write[i]         = p_wr[i];
            req_size[3*i +: 3]   = p_size[i];
            req_addr[32*i +: 32] = p_addr[i];
            req_wdata[32*i +: 32] = p_wdata[i];
        end
    endtask

    task automatic clear_pending();
        for (int i = 0; i < N; i++) begin
            p_valid[i] = 1'b0;
            p_wr[i]    = 1'b0;
            p_size[i]  = 3'd4;
            p_addr[i]  = 32'h0;
            p_wdata[i] = 32'h0;
        end
    endtask

    task automatic set_pending(input int r, input logic wr, input logic [2:0] sz,
                               input logic [31:0] a, input logic [31:0] wd);
        p_valid[r] = 1'b1;
        p_wr[r]    = wr;
        p_size[r]  = sz;
        p_addr[r]  = a;
        p_wdata[r] = wd;
    endtask

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            if (p_valid[(rr_m + k) % N]) return (rr_m + k) % N;
        end
        return -1;
    endfunction

    // Reference access: legal sizes 1/2/4, optional natural alignment,
    // little-endian bytes, reads return the 4 bytes starting at addr.
    task automatic model_access(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd,
                                output logic er, output int nb);
        int w;
        w  = (sz == 3'd1) ? 1 : (sz == 3'd2) ? 2 : (sz == 3'd4) ? 4 : 0;
        er = (w == 0);
`ifdef MEM_ARB_ALIGN_CHECK_EN
        if (w > 1 && (a % w) != 0) er = 1'b1;
`endif
        rd = 32'h0;
        nb = 0;
        if (!er && wr) begin
            nb = w;
            for (int i = 0; i < w; i++) ref_mem[(a + 32'(i)) & 32'hFFF] = wd[8*i +: 8];
        end else if (!er) begin
            for (int i = 0; i < 4; i++) rd[8*i +: 8] = ref_mem[(a + 32'(i)) & 32'hFFF];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rr_m  = 0;
        clear_pending();
    endtask

    // One complete transaction for the pending requests: check grant, the
    // ACCESS cycle, response latency, response stability while stalled for
    // 'hold' cycles, and the handshake. Returns DUT and model responses.
    task automatic run_round(input int hold, output logic [31:0] got_rd, output logic got_err,
                             output logic [31:0] m_rd, output logic m_err, output int g);
        int           eg, n, p0, m_nb;
        logic [N-1:0] oh;
        got_rd = 32'h0; got_err = 1'b0; m_rd = 32'h0; m_err = 1'b0; g = -1;
        @(negedge clk);
        drive_ports();
        resp_ready = '0;
        eg = model_grant();
        #1;
        n = 0;
        while (req_ready == '0 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        oh = '0;
        if (eg >= 0) oh[eg] = 1'b1;
        check("grant", 32'(req_ready), 32'(oh));
        check("accept_wait", n, 0);
        for (int k = N - 1; k >= 0; k--) if (req_ready[k]) g = k;
        if (g < 0) begin
            do_reset();
            return;
        end
        p0 = wr_pulses;
        @(posedge clk);
        model_access(p_wr[g], p_size[g], p_addr[g], p_wdata[g], m_rd, m_err, m_nb);
        p_valid[g] = 1'b0;
        @(negedge clk);
        drive_ports();
        check("access_bytes", 32'(mem_bytes_to_write), m_nb);
        check("access_addr", mem_write_addr, p_addr[g]);
        check("access_no_resp", 32'(resp_valid), 0);
        @(negedge clk);
        n = 0;
        while (!resp_valid[g] && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("resp_latency", n, 0);
        if (!resp_valid[g]) begin
            do_reset();
            return;
        end
        oh = '0;
        oh[g] = 1'b1;
        check("resp_onehot", 32'(resp_valid), 32'(oh));
        got_rd  = resp_rdata;
        got_err = resp_err;
        for (int h = 0; h < hold; h++) begin
            req_valid = '1;
            @(negedge clk);
            check("stall_valid", 32'(resp_valid), 32'(oh));
            check("stall_rdata", resp_rdata, got_rd);
            check("stall_err", 32'(resp_err), 32'(got_err));
            check("stall_no_grant", 32'(req_ready), 0);
            check("stall_no_write", 32'(mem_bytes_to_write), 0);
        end
        drive_ports();
        resp_ready[g] = 1'b1;
        @(negedge clk);
        req_valid  = '0;
        resp_ready = '0;
        check("resp_done", 32'(resp_valid), 0);
        check("write_pulses", wr_pulses - p0, (m_nb != 0) ? 1 : 0);
        rr_m = (g + 1) % N;
    endtask

    typedef struct {
        int          r;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        int          hold;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, mrd;
        logic        er, mer;
        int          g, rr0, mism, p0, nb;
        logic [N-1:0] oh;

        vecs.push_back('{0, 1'b1, 3'd4, 32'h100, 32'hffff_ffff, 0, 32'h0, 1'b0});
        vecs.push_back('{0, 1'b0, 3'd4, 32'h100, 32'h0, 0, 32'hffff_ffff, 1'b0});
        vecs.push_back('{1, 1'b1, 3'd4, 32'h104, 32'hdead_beef, 0, 32'h0, 1'b0});
        vecs.push_back('{1, 1'b1, 3'd2, 32'h104, 32'hb0ba_cafe, 0, 32'h0, 1'b0});
        vecs.push_back('{0, 1'b0, 3'd4, 32'h104, 32'h0, 0, 32'hdead_cafe, 1'b0});
        vecs.push_back('{1, 1'b0, 3'd4, 32'h100, 32'h0, 5, 32'hffff_ffff, 1'b0});
        vecs.push_back('{0, 1'b1, 3'd3, 32'h108, 32'h1234_5678, 0, 32'h0, 1'b1});
        vecs.push_back('{1, 1'b0, 3'd4, 32'h108, 32'h0, 0, 32'h0, 1'b0});
`ifdef MEM_ARB_ALIGN_CHECK_EN
        vecs.push_back('{0, 1'b1, 3'd4, 32'h201, 32'haabb_ccdd, 0, 32'h0, 1'b1});
        vecs.push_back('{1, 1'b0, 3'd4, 32'h200, 32'h0, 0, 32'h0, 1'b0});
        vecs.push_back('{0, 1'b1, 3'd2, 32'h301, 32'h0000_1234, 0, 32'h0, 1'b1});
        vecs.push_back('{1, 1'b0, 3'd4, 32'h300, 32'h0, 0, 32'h0, 1'b0});
`else
        vecs.push_back('{0, 1'b1, 3'd4, 32'h201, 32'haabb_ccdd, 0, 32'h0, 1'b0});
        vecs.push_back('{1, 1'b0, 3'd4, 32'h200, 32'h0, 0, 32'hbbcc_dd00, 1'b0});
        vecs.push_back('{0, 1'b1, 3'd2, 32'h301, 32'h0000_1234, 0, 32'h0, 1'b0});
        vecs.push_back('{1, 1'b0, 3'd4, 32'h300, 32'h0, 0, 32'h0012_3400, 1'b0});
`endif
        vecs.push_back('{0, 1'b1, 3'd1, 32'h10B, 32'h0000_0077, 0, 32'h0, 1'b0});
        vecs.push_back('{1, 1'b0, 3'd4, 32'h108, 32'h0, 0, 32'h7700_0000, 1'b0});
        vecs.push_back('{0, 1'b0, 3'd0, 32'h100, 32'h0, 0, 32'h0, 1'b1});
        vecs.push_back('{1, 1'b0, 3'd7, 32'h100, 32'h0, 0, 32'h0, 1'b1});
`ifdef MEM_ARB_ALIGN_CHECK_EN
        vecs.push_back('{0, 1'b0, 3'd4, 32'h102, 32'h0, 0, 32'h0, 1'b1});
`else
        vecs.push_back('{0, 1'b0, 3'd4, 32'h102, 32'h0, 0, 32'hcafe_ffff, 1'b0});
`endif
        vecs.push_back('{1, 1'b1, 3'd2, 32'h106, 32'haaaa_5555, 0, 32'h0, 1'b0});
        vecs.push_back('{0, 1'b0, 3'd4, 32'h104, 32'h0, 2, 32'h5555_cafe, 1'b0});

        // Reset state, with requests already pending during reset.
        clear_pending();
        req_valid = '1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_err", 32'(resp_err), 0);
        check("rst_bytes", 32'(mem_bytes_to_write), 0);
        check("rst_fetch_addr", mem_fetch_addr, 0);
        req_valid = '0;
        rst_n = 1'b1;

        // Directed vectors.
        foreach (vecs[i]) begin
            clear_pending();
            set_pending(vecs[i].r, vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wd);
            run_round(vecs[i].hold, rd, er, mrd, mer, g);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            $display("[TB] vec%0d req%0d wr=%0b size=%0d addr=0x%03h -> rdata=0x%08h err=%0b",
                     i, vecs[i].r, vecs[i].wr, vecs[i].sz, vecs[i].addr, rd, er);
        end

        // Both requesters streaming writes with resp_ready high: grants
        // alternate, one transaction every 3 cycles, write only in ACCESS.
        clear_pending();
        rr0 = rr_m;
        @(negedge clk);
        req_valid  = '1;
        req_write  = '1;
        req_size   = {3'd4, 3'd4};
        req_addr   = {32'h604, 32'h600};
        req_wdata  = {32'h2222_2222, 32'h1111_1111};
        resp_ready = '1;
        for (int c = 0; c < 12; c++) begin
            #1;
            oh = '0;
            oh[(rr0 + c / 3) % N] = 1'b1;
            check("tp_ready", 32'(req_ready), (c % 3 == 0) ? 32'(oh) : 0);
            check("tp_bytes", 32'(mem_bytes_to_write), (c % 3 == 1) ? 4 : 0);
            check("tp_resp", 32'(resp_valid), (c % 3 == 2) ? 32'(oh) : 0);
            if (c % 3 == 0) $display("[TB] stream cycle %0d grant=%b", c, req_ready);
            @(negedge clk);
        end
        req_valid  = '0;
        resp_ready = '0;
        model_access(1'b1, 3'd4, 32'h600, 32'h1111_1111, mrd, mer, nb);
        model_access(1'b1, 3'd4, 32'h604, 32'h2222_2222, mrd, mer, nb);

        // Randomized concurrent traffic against the reference model.
        clear_pending();
        for (int t = 0; t < 150; t++) begin
            int sizes[8] = '{1, 2, 4, 4, 4, 3, 0, 2};
            for (int i = 0; i < N; i++) begin
                if (p_valid[i] && $urandom_range(7) == 0) begin
                    p_valid[i] = 1'b0;
                end else if (!p_valid[i] && $urandom_range(1) == 1) begin
                    set_pending(i, 1'($urandom_range(1)), 3'(sizes[$urandom_range(7)]),
                                32'h400 + 32'($urandom_range(63)), $urandom);
                end
            end
            if (!p_valid[0] && !p_valid[1]) begin
                set_pending($urandom_range(N - 1), 1'b0, 3'd4, 32'h400 + 32'($urandom_range(60)), 32'h0);
            end
            run_round($urandom_range(2), rd, er, mrd, mer, g);
            check("rand_rdata", rd, mrd);
            check("rand_err", 32'(er), 32'(mer));
            $display("[TB] rand%0d grant=%0d rdata=0x%08h err=%0b", t, g, rd, er);
        end

        // Leave nonzero read data on the response bus (rr pointer -> 1).
        clear_pending();
        set_pending(0, 1'b0, 3'd4, 32'h100, 32'h0);
        run_round(0, rd, er, mrd, mer, g);
        check("pre_rst_rdata", rd, 32'hffff_ffff);

        // Reset asserted in the middle of a write's ACCESS cycle.
        clear_pending();
        set_pending(0, 1'b1, 3'd4, 32'h500, 32'h1122_3344);
        @(negedge clk);
        drive_ports();
        #1;
        check("midrst_accept", 32'(req_ready), 1);
        p0 = wr_pulses;
        @(negedge clk);
        check("midrst_access_bytes", 32'(mem_bytes_to_write), 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_bytes", 32'(mem_bytes_to_write), 0);
        check("midrst_req_ready", 32'(req_ready), 0);
        check("midrst_resp_valid", 32'(resp_valid), 0);
        check("midrst_rdata", resp_rdata, 0);
        check("midrst_err", 32'(resp_err), 0);
        check("midrst_fetch_addr", mem_fetch_addr, 0);
        check("midrst_write_addr", mem_write_addr, 0);
        check("midrst_write_data", mem_write_data, 0);
        @(negedge clk);
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_mem_word", {tb_mem[12'h503], tb_mem[12'h502], tb_mem[12'h501], tb_mem[12'h500]}, 0);
        check("midrst_no_pulse", wr_pulses - p0, 0);
        $display("[TB] reset during ACCESS: bytes_to_write=%0d word=0x%02h%02h%02h%02h",
                 mem_bytes_to_write, tb_mem[12'h503], tb_mem[12'h502], tb_mem[12'h501], tb_mem[12'h500]);

        // After reset the pointer restarts at requester 0.
        rr_m = 0;
        clear_pending();
        set_pending(0, 1'b0, 3'd4, 32'h100, 32'h0);
        set_pending(1, 1'b0, 3'd4, 32'h104, 32'h0);
        run_round(0, rd, er, mrd, mer, g);
        check("post_rst_grant", g, 0);
        check("post_rst_rdata0", rd, mrd);
        run_round(0, rd, er, mrd, mer, g);
        check("post_rst_grant1", g, 1);
        check("post_rst_rdata1", rd, mrd);

        // Memory contents must match the reference exactly.
        mism = 0;
        for (int a = 0; a < 4096; a++) begin
            if (tb_mem[a] !== ref_mem[a]) mism++;
        end
        check("mem_final", mism, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the data-side port of the CPU memory (fetch_addr/fetched_data read path plus write_addr/write_data/bytes_to_write write path) between NUM_REQ requesters, e.g. load/store unit and image loader/debug.
- Round-robin arbitration, valid/ready request and response handshakes, one transaction in flight.
- Sits between requesters and memory; the instruction port is untouched.

Parameters:
- NUM_REQ, 2, number of requesters (2..4)
- ADDR_W, 32, address width
- DATA_W, 32, data width (memory word)

Ports:
- clk  in  1  clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  request valid per requester
- req_ready  out  NUM_REQ  request accepted (one-hot or zero)
- req_write  in  NUM_REQ  1=write, 0=read
- req_size  in  3*NUM_REQ  bytes: 1, 2 or 4
- req_addr  in  ADDR_W*NUM_REQ  byte address
- req_wdata  in  DATA_W*NUM_REQ  write data, little-endian, low bytes used
- resp_valid  out  NUM_REQ  response valid
- resp_ready  in  NUM_REQ  response consumed
- resp_rdata  out  DATA_W  read data (shared bus, qualified by resp_valid)
- resp_err  out  1  error flag, qualified by resp_valid
- mem_fetch_addr  out  ADDR_W  to memory fetch_addr
- mem_fetched_data  in  DATA_W  from memory fetched_data (combinational read)
- mem_write_addr  out  ADDR_W  to memory write_addr
- mem_write_data  out  DATA_W  to memory write_data
- mem_bytes_to_write  out  3  to memory bytes_to_write; 0 = no-op

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset state IDLE, rr pointer 0.
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, mem_* addresses and data=0, mem_bytes_to_write=0.
- IDLE:
  - If any req_valid, grant the first valid requester at or after the rr pointer (wrapping).
  - Assert req_ready[g] combinationally in that cycle.
  - Latch write, size, addr and wdata. Go to ACCESS.
  - If no req_valid, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_fetch_addr = mem_write_addr = latched addr; mem_write_data = latched wdata.
  - Write: mem_bytes_to_write = size, so memory commits at the posedge ending ACCESS. Read: mem_bytes_to_write = 0, and resp_rdata registers mem_fetched_data at that posedge.
  - Go to RESP.
- RESP:
  - resp_valid[g]=1. Hold resp_rdata and resp_err stable until resp_ready[g].
  - Write response: rdata = 0.
  - On handshake: go to IDLE, rr pointer = g+1 mod NUM_REQ.
- mem_bytes_to_write is nonzero only in ACCESS, and is decoded from state so reset forces 0 immediately.
- Latency: accept cycle, read data in resp_rdata 2 cycles after accept. Peak throughput 1 transaction per 3 cycles with resp_ready held high.
- Invalid size (0, 3, 5-7):
  - No memory side effect (bytes_to_write stays 0).
  - Response still issued with resp_err=1, rdata=0.
- Reads always return the full word at addr. Requesters extract bytes.
- Simultaneous requests: round robin guarantees each requester is granted within NUM_REQ transactions.
- A requester dropping req_valid before acceptance is legal; a non-accepted request is never partially performed.
- req_valid from the same requester during its own RESP is not accepted until IDLE.
- Reset mid-ACCESS aborts with no write; reset mid-RESP drops the response.
- Addresses pass through unaligned (memory handles unaligned writes) unless the optional feature is enabled.

Optional Feature:
- Macro: MEM_ARB_ALIGN_CHECK_EN
- Defined:
  - Size 2 with addr[0]=1 is misaligned; size 4 with addr[1:0]!=0 is misaligned.
  - A misaligned request is treated as invalid size: no write, rdata=0, resp_err=1.
- Undefined: no alignment check; resp_err only flags invalid size.

Test Plan:
- Reset then single write (req0, addr 0x100, data 0xffff_ffff, size 4), then read 0x100 -> memory written once (bytes_to_write=4 for exactly one cycle); read resp_rdata=0xffff_ffff, resp_err=0.
- Write 0xdead_beef size 4 at 0x104, then 0xb0ba_cafe size 2 at 0x104, then read 0x104 -> 0xdead_cafe.
- Both requesters hold req_valid continuously, resp_ready=1 -> grants alternate 0,1,0,1; each transaction 3 cycles; bytes_to_write=0 in IDLE/RESP.
- Read with resp_ready held low for 5 cycles -> resp_valid and resp_rdata stable; no new grant until the handshake.
- Size 3 request -> no memory write, resp_err=1. With MEM_ARB_ALIGN_CHECK_EN: size 4 at 0x101 -> resp_err=1. Without the macro: writing 0xaabb_ccdd at 0x101 over zeros makes the read of 0x100 return 0xbbcc_dd00.
- Assert rst_n low during ACCESS of a write -> bytes_to_write drops to 0 immediately, memory word unchanged, all outputs at reset values, FSM in IDLE.
